// File: rtl/delay_line_pkg.sv
// Shared constants, width helpers and FSM encoding
// for the variable-depth delay line.
package delay_line_pkg;

  localparam int MAX_DEPTH_LIMIT = 64;

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Width of a depth value that can hold 0..max_depth
  function automatic int dw(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction

  function automatic int aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/delay_line_srl.sv
// Data-only tapped shift register, one cascaded
// SRL per bit; no reset, powers up at zero.
module srl_tap
  import delay_line_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW = aw(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_d,
  input  logic [AW-1:0]    i_addr,
  output logic [WIDTH-1:0] o_q
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [DEPTH-1:0] r_sr = '0;

    always_ff @(posedge i_clk) begin
      if (i_ce)
        r_sr <= (r_sr << 1) | DEPTH'(i_d[b]);
    end

    assign o_q[b] = r_sr[i_addr];
  end

endmodule

// File: rtl/delay_line.sv
// Runtime-depth delay line with valid tracking,
// fill FSM, flush and checked depth loads.
module delay_line
  import delay_line_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MAX_DEPTH  = 32,
  parameter int OUT_REG    = 1,
  parameter int INIT_DEPTH = 1,
  localparam int DW = dw(MAX_DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] i,
  input  logic             i_valid,
  input  logic             en,
  input  logic [DW-1:0]    depth_in,
  input  logic             depth_load,
  input  logic             flush,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  output logic             primed,
  output logic             depth_err
);

  localparam int AW = aw(MAX_DEPTH);

  state_t           r_state;
  state_t           w_nstate;
  logic [DW-1:0]    depth_r;
  logic [DW-1:0]    r_cnt;
  logic [DW-1:0]    w_ncnt;
  logic [DW-1:0]    w_cnt_inc;
  logic [MAX_DEPTH-1:0] r_vld;
  logic             r_err;
  logic             w_load_ok;
  logic             w_flush;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_tap_d;
  logic             w_tap_v;

  assign w_load_ok = depth_load
                   && (depth_in != '0)
                   && (depth_in <= DW'(MAX_DEPTH));
  assign w_flush   = flush | w_load_ok;
  assign w_addr    = AW'(depth_r - 1'b1);
  assign w_tap_v   = r_vld[w_addr];
  assign w_cnt_inc = r_cnt + 1'b1;

  srl_tap #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DEPTH)
  ) u_srl (
    .i_clk  (CLK),
    .i_ce   (en),
    .i_d    (i),
    .i_addr (w_addr),
    .o_q    (w_tap_d)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_FILL;
      r_cnt   <= '0;
      depth_r <= DW'(INIT_DEPTH);
      r_vld   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_err   <= depth_load & ~w_load_ok;
      if (w_load_ok)
        depth_r <= depth_in;
      // Flush wins over the sample entering this cycle
      if (w_flush)
        r_vld <= '0;
      else if (en)
        r_vld <= (r_vld << 1) | MAX_DEPTH'(i_valid);
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    if (w_flush) begin
      w_nstate = S_FILL;
      w_ncnt   = '0;
    end else if (en) begin
      unique case (r_state)
        S_FILL: begin
          w_ncnt = w_cnt_inc;
          if (w_cnt_inc >= depth_r)
            w_nstate = S_RUN;
        end
        S_RUN: w_nstate = S_RUN;
        default: w_nstate = S_FILL;
      endcase
    end
  end

  assign primed    = (r_state == S_RUN);
  assign depth_err = r_err;

  if (OUT_REG != 0) begin : g_reg
    logic [WIDTH-1:0] r_o;
    logic             r_ov;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_o  <= '0;
        r_ov <= 1'b0;
      end else begin
        r_o  <= w_tap_d;
        r_ov <= w_tap_v;
      end
    end

    assign o       = r_o;
    assign o_valid = r_ov & primed;
  end else begin : g_comb
    assign o       = w_tap_d;
    assign o_valid = w_tap_v & primed;
  end

endmodule

// File: tb/tb_delay_line.sv
// Randomised directed bench for delay_line against
// a queue-based history model of the delay line.
module tb_delay_line;

  localparam int W  = 32;
  localparam int MD = 32;
  localparam int OR = 1;
  localparam int ID = 1;
  localparam int DW = $clog2(MD + 1);

  logic          CLK = 1'b0;
  logic          RST;
  logic [W-1:0]  i;
  logic          i_valid;
  logic          en;
  logic [DW-1:0] depth_in;
  logic          depth_load;
  logic          flush;
  logic [W-1:0]  o;
  logic          o_valid;
  logic          primed;
  logic          depth_err;

  delay_line #(
    .WIDTH      (W),
    .MAX_DEPTH  (MD),
    .OUT_REG    (OR),
    .INIT_DEPTH (ID)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .i          (i),
    .i_valid    (i_valid),
    .en         (en),
    .depth_in   (depth_in),
    .depth_load (depth_load),
    .flush      (flush),
    .o          (o),
    .o_valid    (o_valid),
    .primed     (primed),
    .depth_err  (depth_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] d;
    bit           v;
  } ent_t;

  // History of shifted samples, newest first
  ent_t         hist[$];
  int           md;
  int           fills;
  logic [W-1:0] mreg_o;
  bit           mreg_v;
  bit           merr;
  int           n_tot  = 0;
  int           n_pass = 0;
  logic [W-1:0] seq;
  int           errs;

  task automatic chk(string tag, logic [W-1:0] got,
                     logic [W-1:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic ent_t tap();
    ent_t t;
    t.d = '0;
    t.v = 1'b0;
    if (hist.size() >= md)
      t = hist[md-1];
    return t;
  endfunction

  task automatic model_reset();
    foreach (hist[k]) hist[k].v = 1'b0;
    md     = ID;
    fills  = 0;
    mreg_o = '0;
    mreg_v = 1'b0;
    merr   = 1'b0;
  endtask

  task automatic model_edge();
    ent_t t;
    ent_t n;
    bit   ok;
    bit   fl;
    t  = tap();
    ok = depth_load && depth_in >= 1 && depth_in <= MD;
    fl = flush || ok;
    mreg_o = t.d;
    mreg_v = t.v;
    merr   = depth_load && !ok;
    if (en) begin
      n.d = i;
      n.v = i_valid && !fl;
      hist.push_front(n);
      if (hist.size() > 64) void'(hist.pop_back());
    end
    if (fl) begin
      foreach (hist[k]) hist[k].v = 1'b0;
      fills = 0;
    end else if (en && fills < md) begin
      fills++;
    end
    if (ok) md = int'(depth_in);
  endtask

  task automatic check_all();
    bit pr;
    pr = (fills >= md);
    chk("o_valid", W'(o_valid), W'(mreg_v && pr));
    chk("primed", W'(primed), W'(pr));
    chk("depth_err", W'(depth_err), W'(merr));
    chk("o", o, mreg_o);
  endtask

  task automatic drv(bit e, bit v, bit f = 0,
                     bit l = 0, int d = 0);
    en         = e;
    i_valid    = v;
    flush      = f;
    depth_load = l;
    depth_in   = DW'(d);
    i          = seq;
    seq        = seq + 1;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    seq = 0;
    RST = 1'b1;
    drv(0, 0);
    #12;
    model_reset();
    check_all();
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Fixed depth 5, counting data
    drv(0, 0, 0, 1, 5);
    tick();
    seq = 1;
    drv(1, 1);
    tick();
    repeat (4) begin drv(1, 1); tick(); end
    chk("primed_d5", W'(primed), W'(1));
    drv(1, 1);
    tick();
    chk("first_out", o, 32'd1);
    chk("first_vld", W'(o_valid), W'(1));
    repeat (6) begin drv(1, 1); tick(); end

    // Depth 3 with enable gaps
    drv(0, 0, 0, 1, 3);
    tick();
    for (int k = 0; k < 24; k++) begin
      drv(k % 2 == 0, 1'($urandom_range(0, 1)));
      tick();
    end

    // Rejected loads keep the stream going
    errs = 0;
    drv(1, 1, 0, 1, 0);
    tick();
    if (depth_err) errs++;
    drv(1, 1);
    tick();
    if (depth_err) errs++;
    drv(1, 1, 0, 1, MD + 1);
    tick();
    if (depth_err) errs++;
    repeat (6) begin
      drv(1, 1);
      tick();
      if (depth_err) errs++;
    end
    chk("err_pulses", W'(errs), W'(2));

    // Flush mid-stream at depth 8
    drv(0, 0, 0, 1, 8);
    tick();
    repeat (15) begin drv(1, 1); tick(); end
    drv(1, 1, 1);
    tick();
    repeat (12) begin drv(1, 1); tick(); end

    // Flush together with load of depth 2
    drv(1, 1, 1, 1, 2);
    tick();
    repeat (6) begin drv(1, 1); tick(); end

    // Random mix
    for (int k = 0; k < 300; k++) begin
      drv($urandom_range(0, 3) != 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 29) == 0,
          $urandom_range(0, 24) == 0,
          int'($urandom_range(0, 40)));
      i = $urandom;
      tick();
    end

    // Async reset between edges mid-stream
    drv(0, 0, 0, 1, 4);
    tick();
    repeat (8) begin drv(1, 1); tick(); end
    drv(0, 0);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    chk("rst_o_valid", W'(o_valid), W'(0));
    chk("rst_primed", W'(primed), W'(0));
    chk("rst_err", W'(depth_err), W'(0));
    chk("rst_o", o, '0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (6) begin drv(1, 1); tick(); end
    chk("post_rst_primed", W'(primed), W'(1));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/delay_line.md
DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (1..256).
REQ-002 SHALL have parameter MAX_DEPTH, default 32, maximum delay in enabled cycles (1..64).
REQ-003 SHALL have parameter OUT_REG, default 1, 1 = registered output, 0 = combinational tap output.
REQ-004 SHALL have parameter INIT_DEPTH, default 1, depth after reset (1..MAX_DEPTH).
REQ-005 SHALL have port CLK  input  1  clock; all state on rising edge.
REQ-006 SHALL have port RST  input  1  reset; one clock, asynchronous, active-high.
REQ-007 SHALL have port i  input  WIDTH  data in.
REQ-008 SHALL have port i_valid  input  1  marks i as a valid sample.
REQ-009 SHALL have port en  input  1  shift enable; no shift when 0.
REQ-010 SHALL have port depth_in  input  DW  new depth, where DW = clog2(MAX_DEPTH+1).
REQ-011 SHALL have port depth_load  input  1  load depth_in this cycle.
REQ-012 SHALL have port flush  input  1  invalidate all in-flight samples.
REQ-013 SHALL have port o  output  WIDTH  delayed data.
REQ-014 SHALL have port o_valid  output  1  o carries a valid sample.
REQ-015 SHALL have port primed  output  1  delay line has filled to the current depth since the last flush, load or reset.
REQ-016 SHALL have port depth_err  output  1  one-cycle pulse on a rejected depth load.

Function
REQ-017 SHALL hold the current depth D in register depth_r, range 1..MAX_DEPTH.
REQ-018 SHALL shift (i, i_valid) into the line only on cycles with en=1.
REQ-019 SHALL, with OUT_REG=0, present on o/o_valid the sample shifted in D enabled cycles earlier.
REQ-020 SHALL, with OUT_REG=1, register that tap every CLK cycle regardless of en, adding exactly one clock of latency.
REQ-021 SHALL reset to 0 the valid bits, the registered output and the fill counter; the data storage SHALL NOT be reset and SHALL power up at 0.
REQ-022 SHALL force o_valid=0 whenever primed=0.
REQ-023 SHALL run a two-state FSM. In FILL, the fill counter increments on en and the FSM moves to RUN when the count reaches D. In RUN, the FSM returns to FILL with count 0 on flush or on an accepted load.
REQ-024 SHALL drive primed=1 exactly in state RUN.
REQ-025 SHALL accept depth_load only when 1<=depth_in<=MAX_DEPTH. On acceptance it SHALL update depth_r next cycle and apply an implicit flush.
REQ-026 SHALL, for depth_load with depth_in=0 or depth_in>MAX_DEPTH, leave depth_r unchanged, apply no flush, and pulse depth_err for one cycle.
REQ-027 SHALL on flush clear all valid bits, including the sample entering that cycle, and the fill counter; data bits are unaffected.
REQ-028 SHALL resolve a simultaneous flush and accepted load as a single flush with the new depth.
REQ-029 SHALL treat flush, or an accepted load, with en=1 as flush-wins: the entering sample is invalidated.
REQ-030 SHALL, with en=0, freeze the line, counter and FSM; a registered o SHALL still track the tap.

Reset
REQ-031 SHALL, on asynchronous RST assertion, immediately drive o_valid=0, primed=0 and depth_err=0; o SHALL be 0 when OUT_REG=1.
REQ-032 SHALL, on RST assertion, set depth_r=INIT_DEPTH and the FSM to FILL with count 0.
REQ-033 SHALL, on RST assertion mid-operation, discard all in-flight valid samples; no stale o_valid is permitted after release.
REQ-034 SHALL resume normal operation on the first CLK edge after RST deassertion.

Structure
REQ-035 SHALL place MAX_DEPTH_LIMIT=64, the DW width function and the FSM state encoding in the shared package delay_line_pkg.
REQ-036 SHALL implement storage as one sub-module srl_tap: a per-bit cascaded SRL chain with a runtime address, data only, no reset. The valid chain SHALL be resettable flops in delay_line.

Verification
REQ-037 SHALL verify fixed depth: WIDTH=32, OUT_REG=1, load D=5, en=1 constant, i=counter 1,2,3,... -> o=1 with o_valid=1 six clocks after i=1 was shifted in; primed rises after 5 enabled cycles.
REQ-038 SHALL verify en gaps: D=3, en toggling 1,0,1,0,... -> each sample emerges after 3 enabled cycles; o_valid never asserts for a sample shifted with i_valid=0.
REQ-039 SHALL verify bad load: depth_in=0, then depth_in=MAX_DEPTH+1 -> depth_err pulses twice, D unchanged, output stream uninterrupted.
REQ-040 SHALL verify flush mid-stream: D=8, flush while en=1 -> o_valid=0 for the next 8 enabled cycles, then the first post-flush sample appears.
REQ-041 SHALL verify simultaneous flush and load D=2 -> single flush; the next valid sample appears after 2 enabled cycles plus OUT_REG.
REQ-042 SHALL verify async reset mid-stream, asserted between clock edges -> o_valid and primed drop without a clock edge, and D=INIT_DEPTH after release.
